// File: rtl/doublecrack.sv
// doublecrack: brute-force ARC4 key search with two lockstep engines on keys k, k+1.
// Build option: DOUBLECRACK_EARLY_EXIT_EN ends a round as soon as both engines fail.
module doublecrack #(
    parameter int         KEY_W = 24,
    parameter logic [7:0] PT_LO = 8'h20,
    parameter logic [7:0] PT_HI = 8'h7E
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             rdy,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic [7:0]       ct_addr,
    input  logic [7:0]       ct_rddata
);

    typedef enum logic [2:0] {
        S_RST, S_IDLE, S_LEN0, S_LEN1, S_INIT, S_KSA, S_PRGA, S_JUDGE
    } state_t;

    localparam logic [KEY_W-1:0] K_LAST = {{(KEY_W-1){1'b1}}, 1'b0};

    state_t           r_state, w_next;
    logic [KEY_W-1:0] r_k, r_key;
    logic             r_kv;
    logic [7:0]       r_addr, r_len, r_i, r_cnt;
    logic [1:0]       r_m, r_ph, r_fail;
    logic [7:0]       r_j [2];
    logic [7:0]       r_si[2];
    logic [7:0]       r_sj[2];
    logic [7:0]       r_t [2];
    logic [7:0]       r_s [2][256];

    logic [7:0]       w_ra[2];
    logic [7:0]       w_rd[2];
    logic [7:0]       w_wa[2];
    logic [7:0]       w_wd[2];
    logic [7:0]       w_kb[2];
    logic [7:0]       w_pt[2];
    logic [1:0]       w_we, w_bad;
    logic [KEY_W-1:0] w_ek[2];
    logic             w_prga_end;

    // State register; reset parks the FSM outside IDLE so rdy stays low
    always_ff @(posedge clk) begin
        if (rst_n) r_state <= S_RST;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST:  w_next = S_IDLE;
            S_IDLE: if (en) w_next = S_LEN0;
            S_LEN0: w_next = S_LEN1;
            S_LEN1: w_next = S_INIT;
            S_INIT: if (r_i == 8'hFF) w_next = S_KSA;
            S_KSA:  if (r_ph == 2'd2 && r_i == 8'hFF) w_next = S_PRGA;
            S_PRGA: if (r_ph == 2'd0 && w_prga_end) w_next = S_JUDGE;
            S_JUDGE: begin
                if (r_fail != 2'b11 || r_k == K_LAST) w_next = S_IDLE;
                else                                  w_next = S_INIT;
            end
            default: w_next = S_RST;
        endcase
    end

    // Outputs are straight from registers
    always_comb begin
        rdy       = (r_state == S_IDLE);
        key       = r_key;
        key_valid = r_kv;
        ct_addr   = r_addr;
    end

`ifdef DOUBLECRACK_EARLY_EXIT_EN
    assign w_prga_end = (r_cnt == r_len) || (r_fail == 2'b11);
`else
    assign w_prga_end = (r_cnt == r_len);
`endif

    // Per-engine key byte, plaintext and acceptance test
    always_comb begin
        for (int e = 0; e < 2; e++) begin
            w_ek[e] = (e == 0) ? r_k : (r_k | KEY_W'(1));
            case (r_m)
                2'd0:    w_kb[e] = w_ek[e][23:16];
                2'd1:    w_kb[e] = w_ek[e][15:8];
                default: w_kb[e] = w_ek[e][7:0];
            endcase
            w_rd[e]  = r_s[e][w_ra[e]];
            w_pt[e]  = ct_rddata ^ w_rd[e];
            w_bad[e] = (w_pt[e] < PT_LO) || (w_pt[e] > PT_HI);
        end
    end

    // S read address: S[i], S[j] or S[t] depending on the sub-phase
    always_comb begin
        for (int e = 0; e < 2; e++) begin
            w_ra[e] = r_i;
            if (r_state == S_KSA || r_state == S_PRGA) begin
                case (r_ph)
                    2'd0:    w_ra[e] = (r_state == S_PRGA) ? r_i + 8'd1 : r_i;
                    2'd1:    w_ra[e] = r_j[e];
                    2'd3:    w_ra[e] = r_t[e];
                    default: w_ra[e] = r_i;
                endcase
            end
        end
    end

    // S write port: identity fill, then swap as S[i]<=S[j] then S[j]<=old S[i]
    always_comb begin
        for (int e = 0; e < 2; e++) begin
            w_we[e] = 1'b0;
            w_wa[e] = r_i;
            w_wd[e] = r_i;
            if (r_state == S_INIT) begin
                w_we[e] = 1'b1;
            end else if ((r_state == S_KSA || r_state == S_PRGA) && r_ph == 2'd1) begin
                w_we[e] = 1'b1;
                w_wd[e] = w_rd[e];
            end else if ((r_state == S_KSA || r_state == S_PRGA) && r_ph == 2'd2) begin
                w_we[e] = 1'b1;
                w_wa[e] = r_j[e];
                w_wd[e] = r_si[e];
            end
`ifdef DOUBLECRACK_EARLY_EXIT_EN
            if (r_state == S_PRGA && r_fail[e]) w_we[e] = 1'b0;
`endif
        end
    end

    // S arrays are rebuilt by INIT every round, so they carry no reset
    always_ff @(posedge clk) begin
        for (int e = 0; e < 2; e++)
            if (w_we[e]) r_s[e][w_wa[e]] <= w_wd[e];
    end

    // Search datapath: counters, engine indices, verdicts and result
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_k <= '0; r_key <= '0; r_kv <= 1'b0;
            r_addr <= 8'd1; r_len <= '0; r_i <= '0; r_cnt <= '0;
            r_m <= '0; r_ph <= '0; r_fail <= '0;
            for (int e = 0; e < 2; e++) begin
                r_j[e] <= '0; r_si[e] <= '0; r_sj[e] <= '0; r_t[e] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: if (en) begin
                    r_kv <= 1'b0; r_key <= '0; r_k <= '0; r_addr <= 8'd0;
                end
                S_LEN1: begin
                    r_len <= ct_rddata; r_addr <= 8'd1; r_i <= '0;
                end
                S_INIT: begin
                    r_i <= r_i + 8'd1;
                    r_ph <= '0; r_m <= '0;
                    for (int e = 0; e < 2; e++) r_j[e] <= '0;
                end
                S_KSA: case (r_ph)
                    2'd0: begin
                        for (int e = 0; e < 2; e++) begin
                            r_si[e] <= w_rd[e];
                            r_j[e]  <= r_j[e] + w_rd[e] + w_kb[e];
                        end
                        r_ph <= 2'd1;
                    end
                    2'd1: r_ph <= 2'd2;
                    default: begin
                        r_ph <= 2'd0;
                        r_i  <= r_i + 8'd1;
                        r_m  <= (r_m == 2'd2) ? 2'd0 : r_m + 2'd1;
                        if (r_i == 8'hFF) begin
                            for (int e = 0; e < 2; e++) r_j[e] <= '0;
                            r_cnt <= '0; r_fail <= '0;
                        end
                    end
                endcase
                S_PRGA: case (r_ph)
                    2'd0: if (!w_prga_end) begin
                        r_i <= r_i + 8'd1;
                        for (int e = 0; e < 2; e++) begin
                            r_si[e] <= w_rd[e];
                            r_j[e]  <= r_j[e] + w_rd[e];
                        end
                        r_ph <= 2'd1;
                    end
                    2'd1: begin
                        for (int e = 0; e < 2; e++) r_sj[e] <= w_rd[e];
                        r_ph <= 2'd2;
                    end
                    2'd2: begin
                        for (int e = 0; e < 2; e++) r_t[e] <= r_si[e] + r_sj[e];
                        r_ph <= 2'd3;
                    end
                    default: begin
                        for (int e = 0; e < 2; e++)
                            if (w_bad[e]) r_fail[e] <= 1'b1;
                        r_cnt  <= r_cnt + 8'd1;
                        r_addr <= r_addr + 8'd1;
                        r_ph   <= 2'd0;
                    end
                endcase
                S_JUDGE: begin
                    r_addr <= 8'd1; r_i <= '0;
                    if (!r_fail[0]) begin
                        r_key <= r_k; r_kv <= 1'b1;
                    end else if (!r_fail[1]) begin
                        r_key <= r_k | KEY_W'(1); r_kv <= 1'b1;
                    end else if (r_k == K_LAST) begin
                        r_key <= '0; r_kv <= 1'b0;
                    end else begin
                        r_k <= r_k + KEY_W'(2);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_doublecrack.sv
// tb_doublecrack: random ciphertexts checked against a software ARC4 key search.
// Covers reset, zero length, constant memory, odd winner, en handling, mid-search reset.
module tb_doublecrack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b1;
    logic        rdy, key_valid;
    logic [23:0] key;
    logic [7:0]  ct_addr, ct_rddata;
    logic [7:0]  mem[256];
    int          ks[256];
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    // Synchronous ciphertext RAM
    always @(posedge clk) ct_rddata <= mem[ct_addr];

    doublecrack dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key),
        .key_valid(key_valid), .ct_addr(ct_addr), .ct_rddata(ct_rddata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference ARC4 keystream for key k, bytes 1..len into ks[]
    function automatic void gen_ks(input int k, input int len);
        int s[256];
        int kb[3];
        int i, j, t;
        kb[0] = (k >> 16) & 255; kb[1] = (k >> 8) & 255; kb[2] = k & 255;
        for (int a = 0; a < 256; a++) s[a] = a;
        j = 0;
        for (int a = 0; a < 256; a++) begin
            j = (j + s[a] + kb[a % 3]) % 256;
            t = s[a]; s[a] = s[j]; s[j] = t;
        end
        i = 0; j = 0;
        for (int n = 1; n <= len; n++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            ks[n] = s[(s[i] + s[j]) % 256];
        end
    endfunction

    function automatic bit key_ok(input int k);
        int len, pt;
        len = mem[0];
        gen_ks(k, len);
        for (int n = 1; n <= len; n++) begin
            pt = mem[n] ^ ks[n];
            if (pt < 32 || pt > 126) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int first_key(input int limit);
        for (int k = 0; k < limit; k++) if (key_ok(k)) return k;
        return -1;
    endfunction

    // Encrypt a random printable message of length len under key k
    task automatic load_msg(input int k, input int len);
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
        gen_ks(k, len);
        mem[0] = 8'(len);
        for (int n = 1; n <= len; n++)
            mem[n] = 8'($urandom_range(32, 126) ^ ks[n]);
    endtask

    task automatic fill(input logic [7:0] v);
        for (int a = 0; a < 256; a++) mem[a] = v;
    endtask

    task automatic run_search(input string tag, input int exp_key, input int bound,
                              output int cyc);
        @(negedge clk) en = 1'b1;
        @(negedge clk) en = 1'b0;
        check({tag, "_busy"}, {rdy, key_valid}, 2'b00);
        cyc = 0;
        while (!rdy && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done"}, rdy, 1'b1);
        check({tag, "_key"}, key, 24'(exp_key));
        check({tag, "_kv"}, key_valid, 1'b1);
    endtask

    initial begin
        int cyc, k, exp, hit;
        fill(8'h00);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("reset", {rdy, key_valid, key, ct_addr}, {2'b00, 24'h0, 8'h01});
        end
        rst_n = 1'b0; en = 1'b0;
        @(negedge clk);
        check("rel_rdy", {rdy, key_valid, key, ct_addr}, {2'b10, 24'h0, 8'h01});

        run_search("zlen", 0, 1100, cyc);
        check("zlen_lat", cyc < 1100, 1'b1);

        fill(8'h01);
        exp = first_key(256);
        run_search("const", exp, (exp / 2 + 2) * 1100, cyc);

        load_msg(3, 8);
        exp = first_key(4);
        run_search("odd", exp, 3 * 1100, cyc);

        for (int t = 0; t < 3; t++) begin
            k = $urandom_range(0, 13);
            load_msg(k, $urandom_range(3, 10));
            exp = first_key(k + 1);
            run_search($sformatf("rnd%0d", t), exp, (k / 2 + 2) * 1100, cyc);
        end

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_hold", {rdy, key_valid, key, ct_addr}, {2'b11, 24'(exp), 8'h01});
        end
        en = 1'b1;
        @(negedge clk) en = 1'b0;
        check("restart", {rdy, key_valid}, 2'b00);

        repeat (50) @(negedge clk);
        rst_n = 1'b1;
        fill(8'h70);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("mid_rst", {rdy, key_valid, key, ct_addr}, {2'b00, 24'h0, 8'h01});
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rel", {rdy, key_valid, key, ct_addr}, {2'b10, 24'h0, 8'h01});

        @(negedge clk) en = 1'b1;
        @(negedge clk) en = 1'b0;
        hit = 0;
        for (int c = 0; c < 3000 && !hit; c++) begin
            @(negedge clk);
            if (ct_addr == 8'h70) hit = 1;
        end
        check("newlen_hit", hit, 1);
        hit = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            if (ct_addr == 8'h01) hit = 1;
        end
        check("next_round", {hit[0], rdy}, 2'b10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
